// File: rtl/parking_controller_gen2.sv
// parking_controller_gen2: parking-gate controller with a BCD PIN lock, a wrong-attempt alarm,
// tailgating lockout and lot occupancy tracking. All outputs are registered (Moore).
//
// Optional feature, selected at build time:
//   GATE_TIMEOUT_EN - close an open gate that sees no vehicle pass within GATE_TIMEOUT cycles.
//                     Without it, the gate stays open until a pass or a reset.

module parking_controller_gen2 #(
  parameter int unsigned                  PIN_DIGITS   = 4,
  parameter logic [4*PIN_DIGITS-1:0]      CORRECT_PIN  = 16'h3761,
  parameter int unsigned                  MAX_TRIES    = 3,
  parameter int unsigned                  CAPACITY     = 8,
  parameter int unsigned                  GATE_TIMEOUT = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sensor_vehicule,
  input  logic                              sensor_moved_vehicule,
  input  logic                              pin_valid,
  input  logic [4*PIN_DIGITS-1:0]           password_input,
  input  logic                              exit_event,
  output logic                              open_gate,
  output logic                              close_gate,
  output logic                              alarm_wrong_pin,
  output logic                              alarm_blocked,
  output logic                              lot_full,
  output logic [$clog2(CAPACITY+1)-1:0]     occupancy,
  output logic [$clog2(MAX_TRIES+1)-1:0]    wrong_count
);

  localparam int unsigned PIN_W = 4 * PIN_DIGITS;
  localparam int unsigned OCC_W = $clog2(CAPACITY + 1);
  localparam int unsigned WC_W  = $clog2(MAX_TRIES + 1);

  localparam logic [OCC_W-1:0] CapVal   = OCC_W'(CAPACITY);
  localparam logic [WC_W-1:0]  TriesVal = WC_W'(MAX_TRIES);

  typedef enum logic [1:0] {
    StIdle,
    StWaitPin,
    StOpen,
    StBlocked
  } state_e;

  state_e state_q, state_d;

  logic [WC_W-1:0]  wrong_count_q, wrong_count_d;
  logic             alarm_wrong_q, alarm_wrong_d;
  logic [OCC_W-1:0] occupancy_q, occupancy_d;
  logic             lot_full_q, lot_full_d;
  logic             open_gate_q, open_gate_d;
  logic             alarm_blocked_q, alarm_blocked_d;

  // A vehicle crossed the gate this cycle (drives the occupancy increment).
  logic             vehicle_in;
  // The PIN strobe carries the expected code.
  logic             pin_ok;

  assign pin_ok = (password_input == PIN_W'(CORRECT_PIN));

`ifdef GATE_TIMEOUT_EN
  localparam int unsigned TMR_W = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(GATE_TIMEOUT - 1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timed_out;

  assign timed_out = (timer_q == TmrLast);

  // Open-gate dwell counter: restarts on entry to OPEN, counts while OPEN persists.
  always_comb begin
    timer_d = '0;
    if (state_q == StOpen && state_d == StOpen) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // Dwell counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic timed_out;

  assign timed_out = 1'b0;
`endif

  // State and registered-output storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      wrong_count_q   <= '0;
      alarm_wrong_q   <= 1'b0;
      occupancy_q     <= '0;
      lot_full_q      <= 1'b0;
      open_gate_q     <= 1'b0;
      alarm_blocked_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wrong_count_q   <= wrong_count_d;
      alarm_wrong_q   <= alarm_wrong_d;
      occupancy_q     <= occupancy_d;
      lot_full_q      <= lot_full_d;
      open_gate_q     <= open_gate_d;
      alarm_blocked_q <= alarm_blocked_d;
    end
  end

  // Next-state logic: gate sequencing and PIN attempt bookkeeping.
  always_comb begin
    state_d       = state_q;
    wrong_count_d = wrong_count_q;
    alarm_wrong_d = alarm_wrong_q;
    vehicle_in    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sensor_vehicule && !lot_full_q) begin
          state_d = StWaitPin;
        end
      end

      StWaitPin, StBlocked: begin
        if (pin_valid) begin
          if (pin_ok) begin
            state_d       = (state_q == StWaitPin) ? StOpen : StIdle;
            wrong_count_d = '0;
            alarm_wrong_d = 1'b0;
          end else begin
            if (wrong_count_q != TriesVal) begin
              wrong_count_d = wrong_count_q + WC_W'(1);
            end
            alarm_wrong_d = (wrong_count_d == TriesVal);
          end
        end else if (state_q == StWaitPin && !sensor_vehicule) begin
          // Car drove off before entering a PIN; the attempt count is kept.
          state_d = StIdle;
        end
      end

      StOpen: begin
        if (sensor_moved_vehicule) begin
          // A second car already at the entry sensor means it is tailgating.
          vehicle_in = 1'b1;
          state_d    = sensor_vehicule ? StBlocked : StIdle;
        end else if (timed_out) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Occupancy: saturating at both ends; an entry and an exit in one cycle cancel.
  always_comb begin
    occupancy_d = occupancy_q;
    if (vehicle_in && !exit_event) begin
      if (occupancy_q != CapVal) begin
        occupancy_d = occupancy_q + OCC_W'(1);
      end
    end else if (exit_event && !vehicle_in) begin
      if (occupancy_q != '0) begin
        occupancy_d = occupancy_q - OCC_W'(1);
      end
    end
  end

  // Output decode from the next state so registered outputs track the state register.
  always_comb begin
    open_gate_d     = (state_d == StOpen);
    alarm_blocked_d = (state_d == StBlocked);
    lot_full_d      = (occupancy_d == CapVal);
  end

  assign open_gate       = open_gate_q;
  assign close_gate      = ~open_gate_q;
  assign alarm_wrong_pin = alarm_wrong_q;
  assign alarm_blocked   = alarm_blocked_q;
  assign lot_full        = lot_full_q;
  assign occupancy       = occupancy_q;
  assign wrong_count     = wrong_count_q;

endmodule

// File: tb/tb_parking_controller_gen2.sv
// Directed bench for parking_controller_gen2 (CAPACITY=2 so the full-lot case is reachable).
// The gate-timeout case follows GATE_TIMEOUT_EN if the build defines it.

module tb_parking_controller_gen2;

  localparam int unsigned Cap     = 2;
  localparam int unsigned OccW    = $clog2(Cap + 1);
  localparam int unsigned WcW     = $clog2(3 + 1);
  localparam logic [15:0] GoodPin = 16'h3761;
  localparam logic [15:0] BadPin  = 16'h1234;

  logic            clk;
  logic            rst;
  logic            sensor_vehicule;
  logic            sensor_moved_vehicule;
  logic            pin_valid;
  logic [15:0]     password_input;
  logic            exit_event;
  logic            open_gate;
  logic            close_gate;
  logic            alarm_wrong_pin;
  logic            alarm_blocked;
  logic            lot_full;
  logic [OccW-1:0] occupancy;
  logic [WcW-1:0]  wrong_count;

  int unsigned n_vec;
  int unsigned n_err;

  parking_controller_gen2 #(
    .PIN_DIGITS   (4),
    .CORRECT_PIN  (16'h3761),
    .MAX_TRIES    (3),
    .CAPACITY     (Cap),
    .GATE_TIMEOUT (16)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .sensor_vehicule       (sensor_vehicule),
    .sensor_moved_vehicule (sensor_moved_vehicule),
    .pin_valid             (pin_valid),
    .password_input        (password_input),
    .exit_event            (exit_event),
    .open_gate             (open_gate),
    .close_gate            (close_gate),
    .alarm_wrong_pin       (alarm_wrong_pin),
    .alarm_blocked         (alarm_blocked),
    .lot_full              (lot_full),
    .occupancy             (occupancy),
    .wrong_count           (wrong_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".open"},    32'(open_gate),       32'd0);
    check_eq({tag, ".close"},   32'(close_gate),      32'd1);
    check_eq({tag, ".awrong"},  32'(alarm_wrong_pin), 32'd0);
    check_eq({tag, ".ablock"},  32'(alarm_blocked),   32'd0);
    check_eq({tag, ".full"},    32'(lot_full),        32'd0);
    check_eq({tag, ".occ"},     32'(occupancy),       32'd0);
    check_eq({tag, ".wc"},      32'(wrong_count),     32'd0);
  endtask

  initial begin
    n_vec                 = 0;
    n_err                 = 0;
    rst                   = 1'b1;
    sensor_vehicule       = 1'b0;
    sensor_moved_vehicule = 1'b0;
    pin_valid             = 1'b0;
    password_input        = '0;
    exit_event            = 1'b0;
    step();
    step();
    check_reset_values("reset");
    rst = 1'b0;

    // Basic admission: car, correct PIN, pass.
    sensor_vehicule = 1'b1;
    step();
    check_eq("wait.open", 32'(open_gate), 32'd0);
    pin_valid      = 1'b1;
    password_input = GoodPin;
    step();
    check_eq("good.open",  32'(open_gate),  32'd1);
    check_eq("good.close", 32'(close_gate), 32'd0);
    pin_valid             = 1'b0;
    sensor_vehicule       = 1'b0;
    sensor_moved_vehicule = 1'b1;
    step();
    check_eq("pass.open", 32'(open_gate), 32'd0);
    check_eq("pass.occ",  32'(occupancy), 32'd1);
    sensor_moved_vehicule = 1'b0;

    // Wrong PIN sequence up to the alarm, saturation, then recovery.
    sensor_vehicule = 1'b1;
    step();
    pin_valid      = 1'b1;
    password_input = BadPin;
    step();
    check_eq("bad1.wc", 32'(wrong_count), 32'd1);
    check_eq("bad1.al", 32'(alarm_wrong_pin), 32'd0);
    step();
    check_eq("bad2.wc", 32'(wrong_count), 32'd2);
    check_eq("bad2.al", 32'(alarm_wrong_pin), 32'd0);
    step();
    check_eq("bad3.wc", 32'(wrong_count), 32'd3);
    check_eq("bad3.al", 32'(alarm_wrong_pin), 32'd1);
    check_eq("bad3.open", 32'(open_gate), 32'd0);
    step();
    check_eq("bad4.wc_sat", 32'(wrong_count), 32'd3);
    password_input = GoodPin;
    step();
    check_eq("recov.wc",   32'(wrong_count), 32'd0);
    check_eq("recov.al",   32'(alarm_wrong_pin), 32'd0);
    check_eq("recov.open", 32'(open_gate), 32'd1);
    pin_valid = 1'b0;

    // Tailgating: pass while entry sensor is still occupied.
    sensor_moved_vehicule = 1'b1;
    step();
    check_eq("tail.ablock", 32'(alarm_blocked), 32'd1);
    check_eq("tail.close",  32'(close_gate),    32'd1);
    check_eq("tail.occ",    32'(occupancy),     32'd2);
    check_eq("tail.full",   32'(lot_full),      32'd1);
    sensor_moved_vehicule = 1'b0;
    pin_valid      = 1'b1;
    password_input = BadPin;
    step();
    check_eq("blkbad.ablock", 32'(alarm_blocked), 32'd1);
    check_eq("blkbad.wc",     32'(wrong_count),   32'd1);
    password_input = GoodPin;
    step();
    check_eq("blkgood.ablock", 32'(alarm_blocked), 32'd0);
    check_eq("blkgood.wc",     32'(wrong_count),   32'd0);
    check_eq("blkgood.open",   32'(open_gate),     32'd0);
    pin_valid = 1'b0;

    // Lot full: arrival stays idle, a correct PIN is ignored.
    step();
    pin_valid      = 1'b1;
    password_input = GoodPin;
    step();
    check_eq("full.open", 32'(open_gate), 32'd0);
    pin_valid       = 1'b0;
    sensor_vehicule = 1'b0;
    exit_event      = 1'b1;
    step();
    check_eq("exit.occ",  32'(occupancy), 32'd1);
    check_eq("exit.full", 32'(lot_full),  32'd0);
    exit_event = 1'b0;

    // Pass and exit in the same cycle cancel out.
    sensor_vehicule = 1'b1;
    step();
    pin_valid = 1'b1;
    step();
    check_eq("both.open_pre", 32'(open_gate), 32'd1);
    pin_valid             = 1'b0;
    sensor_vehicule       = 1'b0;
    sensor_moved_vehicule = 1'b1;
    exit_event            = 1'b1;
    step();
    check_eq("both.occ",  32'(occupancy), 32'd1);
    check_eq("both.open", 32'(open_gate), 32'd0);
    sensor_moved_vehicule = 1'b0;
    step();
    check_eq("exit1.occ", 32'(occupancy), 32'd0);
    step();
    check_eq("exit0.occ", 32'(occupancy), 32'd0);
    exit_event = 1'b0;

    // Leaving WAIT_PIN without a PIN keeps the attempt count.
    sensor_vehicule = 1'b1;
    step();
    pin_valid      = 1'b1;
    password_input = BadPin;
    step();
    pin_valid       = 1'b0;
    sensor_vehicule = 1'b0;
    step();
    check_eq("leave.wc", 32'(wrong_count), 32'd1);
    pin_valid      = 1'b1;
    password_input = GoodPin;
    step();
    check_eq("idlepin.open", 32'(open_gate), 32'd0);
    check_eq("idlepin.wc",   32'(wrong_count), 32'd1);
    pin_valid = 1'b0;

    // Gate dwell with no pass.
    sensor_vehicule = 1'b1;
    step();
    pin_valid = 1'b1;
    step();
    pin_valid = 1'b0;
    check_eq("dwell.rise", 32'(open_gate), 32'd1);
    for (int k = 1; k < 16; k++) begin
      step();
      check_eq($sformatf("dwell.hold%0d", k), 32'(open_gate), 32'd1);
    end
    step();
`ifdef GATE_TIMEOUT_EN
    check_eq("dwell.timeout", 32'(open_gate), 32'd0);
    check_eq("dwell.occ",     32'(occupancy), 32'd0);
    step();
    pin_valid = 1'b1;
    step();
    pin_valid = 1'b0;
    check_eq("reopen.open", 32'(open_gate), 32'd1);
`else
    check_eq("dwell.stay", 32'(open_gate), 32'd1);
`endif

    // Reset in the middle of OPEN.
    step();
    rst = 1'b1;
    step();
    check_reset_values("midrst");
    rst             = 1'b0;
    sensor_vehicule = 1'b0;
    step();
    check_eq("postrst.open", 32'(open_gate), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
